// File: rtl/clkgen_freq_monitor_if.sv
// Signal bundle between the frequency monitor and its user.
// slave: the monitor itself; master: the logic that enables it and consumes results.
interface clkgen_freq_monitor_if #(
  parameter int CNT_W = 16
);
  logic             enable_i;
  logic             sense_i;
  logic             clear_i;
  logic [CNT_W-1:0] count_o;
  logic             count_valid_o;
  logic             in_range_o;
  logic             locked_o;
  logic             lost_o;

  modport master (
    output enable_i, sense_i, clear_i,
    input  count_o, count_valid_o, in_range_o, locked_o, lost_o
  );

  modport slave (
    input  enable_i, sense_i, clear_i,
    output count_o, count_valid_o, in_range_o, locked_o, lost_o
  );
endinterface

// File: rtl/clkgen_freq_monitor.sv
// Frequency monitor for the PLL-generated clock.
// Counts edges of an asynchronous divide-by-2 toggle (sense_i) over fixed gate
// windows of clk_i, flags whether each window is in range and declares lock
// after LOCK_WINDOWS consecutive good windows.
// Optional feature macro: CLKMON_STICKY_EN (sticky loss-of-lock flag lost_o,
// cleared by clear_i). Without it lost_o is tied 0 and clear_i is ignored.
//
// state   | meaning
// IDLE    | monitor stopped, lock state cleared, count_o holds
// SETTLE  | 4 cycles flushing the synchroniser, edges ignored
// MEASURE | gate window running, edges counted every cycle
module clkgen_freq_monitor #(
  parameter int GATE_CYCLES  = 60000,
  parameter int EXP_MIN      = 4570,
  parameter int EXP_MAX      = 4660,
  parameter int LOCK_WINDOWS = 4,
  parameter int CNT_W        = 16
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  clkgen_freq_monitor_if.slave mon
);

  localparam int WIN_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(GATE_CYCLES - 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_WINDOWS);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t             state;
  logic [1:0]         settle_cnt;
  logic [WIN_W-1:0]   win_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic [GOOD_W-1:0]  good_cnt;
  logic [CNT_W-1:0]   count;
  logic               count_valid;
  logic               in_range;
  logic               locked;
  logic               fall_pend;
  logic               lost;

  logic sync1, sync2, hist;
  logic sense_edge;
  logic [CNT_W-1:0]  edge_cnt_inc;
  logic [GOOD_W-1:0] good_inc;
  logic              win_in_range;

  // Two-flop synchroniser plus history flop; runs in every state so the
  // history is valid as soon as a window opens.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= mon.sense_i;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // Both toggle directions are edges of the monitored clock.
  assign sense_edge = sync2 ^ hist;

  // Edge count including the current cycle, saturating instead of wrapping.
  assign edge_cnt_inc = (sense_edge && (edge_cnt != CNT_MAX)) ? edge_cnt + 1'b1 : edge_cnt;
  assign win_in_range = (int'(edge_cnt_inc) >= EXP_MIN) && (int'(edge_cnt_inc) <= EXP_MAX);
  assign good_inc     = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + 1'b1;

  // Sequencing FSM, gate window, edge counter, window report and lock tracking.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      win_cnt     <= '0;
      edge_cnt    <= '0;
      good_cnt    <= '0;
      count       <= '0;
      count_valid <= 1'b0;
      in_range    <= 1'b0;
      locked      <= 1'b0;
      fall_pend   <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      fall_pend   <= 1'b0;
      if (!mon.enable_i) begin
        // Abandon any partial window; count_o keeps the last full result.
        state      <= IDLE;
        settle_cnt <= '0;
        win_cnt    <= '0;
        edge_cnt   <= '0;
        good_cnt   <= '0;
        in_range   <= 1'b0;
        locked     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state      <= SETTLE;
            settle_cnt <= 2'd3;
          end
          SETTLE: begin
            if (settle_cnt == 2'd0) begin
              state    <= MEASURE;
              win_cnt  <= '0;
              edge_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt - 1'b1;
            end
          end
          MEASURE: begin
            if (win_cnt == WIN_LAST) begin
              // Terminal cycle's edge is included; the next cycle starts a fresh window.
              win_cnt     <= '0;
              edge_cnt    <= '0;
              count       <= edge_cnt_inc;
              count_valid <= 1'b1;
              in_range    <= win_in_range;
              if (win_in_range) begin
                good_cnt <= good_inc;
                locked   <= (good_inc == GOOD_MAX);
              end else begin
                good_cnt  <= '0;
                locked    <= 1'b0;
                fall_pend <= locked;
              end
            end else begin
              win_cnt  <= win_cnt + 1'b1;
              edge_cnt <= edge_cnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef CLKMON_STICKY_EN
  // Sticky loss-of-lock: set one cycle after a window-driven lock drop; set beats clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lost <= 1'b0;
    end else if (fall_pend) begin
      lost <= 1'b1;
    end else if (mon.clear_i) begin
      lost <= 1'b0;
    end
  end
`else
  logic unused_sticky;
  assign unused_sticky = mon.clear_i ^ fall_pend;
  assign lost          = 1'b0;
`endif

  assign mon.count_o       = count;
  assign mon.count_valid_o = count_valid;
  assign mon.in_range_o    = in_range;
  assign mon.locked_o      = locked;
  assign mon.lost_o        = lost;

endmodule

// File: tb/tb_clkgen_freq_monitor.sv
// Scoreboard bench for clkgen_freq_monitor. Instance A uses a shortened gate
// window (600 cycles, toggle every 13 -> 46..47 edges) for the lock/loss/disable
// scenarios; instance B checks counter saturation with CNT_W=8.
`timescale 1ns/1ps
module tb_clkgen_freq_monitor;

  localparam int G_A   = 600;
  localparam int G_B   = 1000;
  localparam int CW_A  = 16;
  localparam int CW_B  = 8;

  typedef struct {
    int lo;
    int hi;
    bit rng;
    bit lck;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clkgen_freq_monitor_if #(.CNT_W(CW_A)) if_a ();
  clkgen_freq_monitor_if #(.CNT_W(CW_B)) if_b ();

  clkgen_freq_monitor #(
    .GATE_CYCLES(G_A), .EXP_MIN(44), .EXP_MAX(48), .LOCK_WINDOWS(4), .CNT_W(CW_A)
  ) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .mon(if_a.slave)
  );

  clkgen_freq_monitor #(
    .GATE_CYCLES(G_B), .EXP_MIN(4570), .EXP_MAX(4660), .LOCK_WINDOWS(4), .CNT_W(CW_B)
  ) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .mon(if_b.slave)
  );

  int checks = 0;
  int errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int per_a = 13;
  int per_b = 3;
  int last_count_a = 0;
  bit exp_lost;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // sense generators: toggle every per_x clocks, hold when per_x == 0
  initial begin
    int c = 0;
    if_a.sense_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (per_a != 0) begin
        c++;
        if (c >= per_a) begin
          if_a.sense_i = ~if_a.sense_i;
          c = 0;
        end
      end else c = 0;
    end
  end

  initial begin
    int c = 0;
    if_b.sense_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (per_b != 0) begin
        c++;
        if (c >= per_b) begin
          if_b.sense_i = ~if_b.sense_i;
          c = 0;
        end
      end else c = 0;
    end
  end

  // monitor A: pop and compare on every report pulse
  always @(negedge clk) begin
    if (rst_n && if_a.count_valid_o) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check_range("a_count", int'(if_a.count_o), e.lo, e.hi);
        check("a_in_range", int'(if_a.in_range_o), int'(e.rng));
        check("a_locked", int'(if_a.locked_o), int'(e.lck));
      end
      last_count_a = int'(if_a.count_o);
    end
  end

  // monitor B
  always @(negedge clk) begin
    if (rst_n && if_b.count_valid_o) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check_range("b_count_sat", int'(if_b.count_o), e.lo, e.hi);
        check("b_in_range", int'(if_b.in_range_o), int'(e.rng));
        check("b_locked", int'(if_b.locked_o), int'(e.lck));
      end
    end
  end

  task automatic push_a(input int lo, input int hi, input bit rng, input bit lck, input int n);
    for (int i = 0; i < n; i++) q_a.push_back('{lo, hi, rng, lck});
  endtask

  task automatic wait_pulses_a(input int n);
    int got = 0;
    int budget = (n + 2) * G_A;
    while (got < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (if_a.count_valid_o) got++;
    end
    if (got < n) check("a_pulse_timeout", got, n);
  endtask

  task automatic wait_pulses_b(input int n);
    int got = 0;
    int budget = (n + 2) * G_B;
    while (got < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (if_b.count_valid_o) got++;
    end
    if (got < n) check("b_pulse_timeout", got, n);
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_count"}, int'(if_a.count_o), 0);
    check({tag, "_valid"}, int'(if_a.count_valid_o), 0);
    check({tag, "_in_range"}, int'(if_a.in_range_o), 0);
    check({tag, "_locked"}, int'(if_a.locked_o), 0);
    check({tag, "_lost"}, int'(if_a.lost_o), 0);
  endtask

  initial begin
    int n;
`ifdef CLKMON_STICKY_EN
    exp_lost = 1'b1;
`else
    exp_lost = 1'b0;
`endif
    if_a.enable_i = 1'b0;
    if_a.clear_i  = 1'b0;
    if_b.enable_i = 1'b0;
    if_b.clear_i  = 1'b0;

    // reset held while sense toggles
    repeat (20) @(negedge clk);
    check_idle_a("rst");
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check_idle_a("post_rst_disabled");

    // nominal: lock at 4th report
    push_a(46, 47, 1'b1, 1'b0, 3);
    push_a(46, 47, 1'b1, 1'b1, 2);
    if_a.enable_i = 1'b1;
    wait_pulses_a(5);

    // stuck sense: count drops to 0, lock lost
    per_a = 0;
    push_a(0, 1, 1'b0, 1'b0, 1);
    push_a(0, 0, 1'b0, 1'b0, 1);
    wait_pulses_a(2);
    @(negedge clk);
    check("lost_after_stuck", int'(if_a.lost_o), int'(exp_lost));
    if_a.clear_i = 1'b1;
    @(negedge clk);
    if_a.clear_i = 1'b0;
    @(negedge clk);
    check("lost_after_clear", int'(if_a.lost_o), 0);

    // out of range: toggle every 12 -> 50 edges, never locks
    if_a.enable_i = 1'b0;
    per_a = 12;
    repeat (10) @(negedge clk);
    push_a(50, 50, 1'b0, 1'b0, 3);
    if_a.enable_i = 1'b1;
    wait_pulses_a(3);

    // disable mid-window, then re-enable latency
    if_a.enable_i = 1'b0;
    per_a = 13;
    repeat (10) @(negedge clk);
    push_a(46, 47, 1'b1, 1'b0, 2);
    if_a.enable_i = 1'b1;
    wait_pulses_a(2);
    n = last_count_a;
    repeat (G_A / 2) @(posedge clk);
    @(negedge clk);
    if_a.enable_i = 1'b0;
    repeat (2 * G_A + 100) @(negedge clk);
    check("dis_locked", int'(if_a.locked_o), 0);
    check("dis_in_range", int'(if_a.in_range_o), 0);
    check("dis_count_hold", int'(if_a.count_o), n);
    push_a(46, 47, 1'b1, 1'b0, 1);
    if_a.enable_i = 1'b1;
    n = 0;
    while (n < G_A + 20) begin
      @(negedge clk);
      n++;
      if (if_a.count_valid_o) break;
    end
    check("reenable_latency", n, G_A + 5);
    if_a.enable_i = 1'b0;

    // saturation on the 8-bit instance
    q_b.push_back('{255, 255, 1'b0, 1'b0});
    q_b.push_back('{255, 255, 1'b0, 1'b0});
    if_b.enable_i = 1'b1;
    wait_pulses_b(2);
    if_b.enable_i = 1'b0;
    repeat (10) @(negedge clk);

    check("a_queue_empty", q_a.size(), 0);
    check("b_queue_empty", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
